imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction word and a sideband tag over a valid/ready handshake. It derives the immediate format either from the opcode or from an external selection code, then returns the sign- or zero-extended XLEN-bit immediate with a format-error flag one cycle later. A 2-entry skid buffer makes it a fully registered pipeline stage: backpressure from execute never forms a combinational path to fetch.

---
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate format, extends the immediate,
// and buffers the result in a two-entry skid buffer so the stage is fully registered.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_selection,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic             fmt_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_Z   = 3'd5;
  localparam logic [2:0] FMT_R   = 3'd6;
  localparam logic [2:0] FMT_BAD = 3'd7;

  function automatic logic [2:0] decode_fmt(input logic [31:0] ins);
    logic [2:0] f;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
      7'b1110011:                         f = ins[14] ? FMT_Z : FMT_I;
      7'b0100011:                         f = FMT_S;
      7'b1100011:                         f = FMT_B;
      7'b0110111, 7'b0010111:             f = FMT_U;
      7'b1101111:                         f = FMT_J;
      7'b0110011:                         f = FMT_R;
      default:                            f = FMT_BAD;
    endcase
    return f;
  endfunction

  // Built at 64 bits and truncated, so one set of formulas serves both XLEN values.
  // Returns {fmt_err, imm}.
  function automatic logic [XLEN:0] extend_imm(input logic [31:0] ins, input logic [2:0] fmt);
    logic [63:0] v;
    logic        err;
    v   = 64'd0;
    err = 1'b0;
    case (fmt)
      FMT_I:   v = {{52{ins[31]}}, ins[31:20]};
      FMT_S:   v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   v = {{32{ins[31]}}, ins[31:12], 12'd0};
      FMT_J:   v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_Z:   v = {59'd0, ins[19:15]};
      FMT_R:   v = 64'd0;
      default: begin
        v   = 64'd0;
        err = 1'b1;
      end
    endcase
    return {err, v[XLEN-1:0]};
  endfunction

  logic [2:0]       fmt_s;
  logic [XLEN:0]    ext_s;
  logic             accept_s;
  logic             consume_s;

  logic             m_valid_r;
  logic [XLEN-1:0]  m_imm_r;
  logic             m_err_r;
  logic [TAG_W-1:0] m_tag_r;
  logic             k_valid_r;
  logic [XLEN-1:0]  k_imm_r;
  logic             k_err_r;
  logic [TAG_W-1:0] k_tag_r;

  // Format selection and immediate extension straight from the input word.
  always_comb begin
    fmt_s = 3'd0;
    if (AUTO_SEL) begin
      fmt_s = decode_fmt(instruction);
    end else begin
      fmt_s = imm_selection;
    end
    ext_s     = extend_imm(instruction, fmt_s);
    accept_s  = in_valid && in_ready;
    consume_s = m_valid_r && out_ready;
  end

  // Skid buffer: M feeds the outputs, K catches the one word accepted while M stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_imm_r   <= '0;
      m_err_r   <= 1'b0;
      m_tag_r   <= '0;
      k_valid_r <= 1'b0;
      k_imm_r   <= '0;
      k_err_r   <= 1'b0;
      k_tag_r   <= '0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      m_imm_r   <= '0;
      m_err_r   <= 1'b0;
      m_tag_r   <= '0;
      k_valid_r <= 1'b0;
      k_imm_r   <= '0;
      k_err_r   <= 1'b0;
      k_tag_r   <= '0;
    end else if (!m_valid_r || consume_s) begin
      // K can only be full while in_ready is low, so K and a new input never collide.
      if (k_valid_r) begin
        m_valid_r <= 1'b1;
        m_imm_r   <= k_imm_r;
        m_err_r   <= k_err_r;
        m_tag_r   <= k_tag_r;
        k_valid_r <= 1'b0;
      end else if (accept_s) begin
        m_valid_r <= 1'b1;
        m_imm_r   <= ext_s[XLEN-1:0];
        m_err_r   <= ext_s[XLEN];
        m_tag_r   <= in_tag;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      k_valid_r <= 1'b1;
      k_imm_r   <= ext_s[XLEN-1:0];
      k_err_r   <= ext_s[XLEN];
      k_tag_r   <= in_tag;
    end else begin
      k_valid_r <= k_valid_r;
    end
  end

  assign in_ready  = !k_valid_r;
  assign out_valid = m_valid_r;
  assign imm_out   = m_imm_r;
  assign fmt_err   = m_err_r;
  assign out_tag   = m_tag_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vector table across three configurations
// plus hand-written backpressure, throughput, flush and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic [2:0]  imm_selection = 3'd0;
  logic [31:0] in_tag = 32'd0;
  logic        out_ready = 1'b0;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32, tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic        rdym, vldm, errm;
  logic [31:0] immm, tagm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_SEL(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instruction(instruction), .imm_selection(imm_selection), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .imm_out(imm32), .fmt_err(err32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_SEL(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instruction(instruction), .imm_selection(imm_selection), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .imm_out(imm64), .fmt_err(err64), .out_tag(tag64));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_SEL(1'b0)) dutm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdym),
    .instruction(instruction), .imm_selection(imm_selection), .in_tag(in_tag),
    .out_valid(vldm), .out_ready(out_ready), .imm_out(immm), .fmt_err(errm), .out_tag(tagm));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] e32;
    logic        e32_err;
    logic [63:0] e64;
    logic        e64_err;
    logic [31:0] em;
    logic        em_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_word(input int k);
    logic [11:0] imm12;
    imm12 = 12'(k);
    return {imm12, 5'd0, 3'd0, 5'd1, 7'b0010011};
  endfunction

  initial begin
    int idx, rx, accepted;
    bit acc_now, cons_now, first;

    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h123450B7, 3'd3, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0, 32'h12345000, 1'b0};
    vecs[3]  = '{32'h000FD073, 3'd5, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0, 32'h0000001F, 1'b0};
    vecs[4]  = '{32'h0080006F, 3'd4, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0, 32'h00000008, 1'b0};
    vecs[5]  = '{32'h800000B7, 3'd3, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h0000007F, 3'd7, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b1};
    vecs[7]  = '{32'h00B50533, 3'd6, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h00112623, 3'd1, 32'h0000000C, 1'b0, 64'h000000000000000C, 1'b0, 32'h0000000C, 1'b0};
    vecs[9]  = '{32'h34011073, 3'd0, 32'h00000340, 1'b0, 64'h0000000000000340, 1'b0, 32'h00000340, 1'b0};
    vecs[10] = '{32'h80002003, 3'd0, 32'hFFFFF800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0, 32'hFFFFF800, 1'b0};
    vecs[11] = '{32'h0000007F, 3'd0, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b0};

    // Reset state
    #12;
    chk("reset out_valid", {63'd0, vld32}, 64'd0);
    chk("reset in_ready", {63'd0, rdy32}, 64'd1);
    chk("reset imm_out", {32'd0, imm32}, 64'd0);
    chk("reset fmt_err", {63'd0, err32}, 64'd0);
    chk("reset out_tag", {32'd0, tag32}, 64'd0);
    chk("reset imm64", imm64, 64'd0);
    rst_n = 1'b1;
    step();

    // Vector table: one word at a time, result one edge after acceptance
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instruction   = vecs[i].instr;
      imm_selection = vecs[i].sel;
      in_tag        = 32'h100 + 32'(i);
      in_valid      = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), {63'd0, vld32}, 64'd1);
      chk($sformatf("v%0d imm32", i), {32'd0, imm32}, {32'd0, vecs[i].e32});
      chk($sformatf("v%0d err32", i), {63'd0, err32}, {63'd0, vecs[i].e32_err});
      chk($sformatf("v%0d tag", i), {32'd0, tag32}, 64'h100 + 64'(i));
      chk($sformatf("v%0d imm64", i), imm64, vecs[i].e64);
      chk($sformatf("v%0d err64", i), {63'd0, err64}, {63'd0, vecs[i].e64_err});
      chk($sformatf("v%0d immsel", i), {32'd0, immm}, {32'd0, vecs[i].em});
      chk($sformatf("v%0d errsel", i), {63'd0, errm}, {63'd0, vecs[i].em_err});
      step();
      chk($sformatf("v%0d drained", i), {63'd0, vld32}, 64'd0);
    end

    // Back-to-back throughput: accept and consume on the same edge
    for (int i = 0; i < 3; i++) begin
      instruction = addi_word(40 + i);
      in_tag      = 32'h300 + 32'(i);
      in_valid    = 1'b1;
      step();
      chk($sformatf("tp%0d tag", i), {32'd0, tag32}, 64'h300 + 64'(i));
      chk($sformatf("tp%0d imm", i), {32'd0, imm32}, 64'(40 + i));
      chk($sformatf("tp%0d in_ready", i), {63'd0, rdy32}, 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: five words offered, output stalled for four cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid    = 1'b1;
      instruction = addi_word(idx);
      in_tag      = 32'h200 + 32'(idx);
      acc_now     = rdy32;
      step();
      if (acc_now) idx++;
      if (c > 0) begin
        chk($sformatf("stall%0d tag", c), {32'd0, tag32}, 64'h200);
        chk($sformatf("stall%0d imm", c), {32'd0, imm32}, 64'd0);
      end
    end
    accepted = idx;
    chk("stall accepted", 64'(accepted), 64'd2);
    chk("stall in_ready", {63'd0, rdy32}, 64'd0);
    chk("stall out_valid", {63'd0, vld32}, 64'd1);

    out_ready = 1'b1;
    rx = 0;
    first = 1'b1;
    for (int c = 0; c < 30 && rx < 5; c++) begin
      in_valid    = (idx < 5);
      instruction = addi_word(idx);
      in_tag      = 32'h200 + 32'(idx);
      acc_now     = in_valid && rdy32;
      cons_now    = vld32 && out_ready;
      if (cons_now) begin
        chk($sformatf("drain%0d tag", rx), {32'd0, tag32}, 64'h200 + 64'(rx));
        chk($sformatf("drain%0d imm", rx), {32'd0, imm32}, 64'(rx));
        rx++;
      end
      step();
      if (acc_now) idx++;
      if (first) begin
        chk("resume in_ready", {63'd0, rdy32}, 64'd1);
        first = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("drain count", 64'(rx), 64'd5);
    step();
    chk("drain empty", {63'd0, vld32}, 64'd0);

    // Flush with both entries full and a new word presented
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid    = 1'b1;
      instruction = addi_word(70 + i);
      in_tag      = 32'h400 + 32'(i);
      step();
    end
    chk("preflush in_ready", {63'd0, rdy32}, 64'd0);
    chk("preflush out_valid", {63'd0, vld32}, 64'd1);
    instruction = addi_word(99);
    in_tag      = 32'h4FF;
    flush       = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", {63'd0, vld32}, 64'd0);
    chk("flush in_ready", {63'd0, rdy32}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("flush dropped", {63'd0, vld32}, 64'd0);

    // Asynchronous reset in the middle of a stalled stream
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid    = 1'b1;
      instruction = addi_word(0 - 5 - i);
      in_tag      = 32'h500 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("prerst out_valid", {63'd0, vld32}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst out_valid", {63'd0, vld32}, 64'd0);
    chk("rst in_ready", {63'd0, rdy32}, 64'd1);
    chk("rst imm_out", {32'd0, imm32}, 64'd0);
    chk("rst fmt_err", {63'd0, err32}, 64'd0);
    chk("rst out_tag", {32'd0, tag32}, 64'd0);
    chk("rst imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("postrst out_valid", {63'd0, vld32}, 64'd0);
    chk("postrst out_tag", {32'd0, tag32}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
